// File: rtl/stump_control_if.sv
// Control bundle between the Stump control unit (master) and the datapath (slave).
// STUMP_CTRL_INSTR_COUNT_EN adds the retired-fetch counter to the bundle.
interface stump_control_if;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic        fetch;
    logic        execute;
    logic        memory;
    logic        ext_op;
    logic        opB_mux_sel;
    logic [1:0]  shift_op;
    logic [2:0]  alu_func;
    logic        cc_en;
    logic        reg_write;
    logic [2:0]  dest;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
`ifdef STUMP_CTRL_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    modport master (
        input  ir, cc,
        output fetch, execute, memory, ext_op, opB_mux_sel, shift_op,
               alu_func, cc_en, reg_write, dest, srcA, srcB
`ifdef STUMP_CTRL_INSTR_COUNT_EN
        , output instr_count
`endif
    );

    modport slave (
        output ir, cc,
        input  fetch, execute, memory, ext_op, opB_mux_sel, shift_op,
               alu_func, cc_en, reg_write, dest, srcA, srcB
`ifdef STUMP_CTRL_INSTR_COUNT_EN
        , input instr_count
`endif
    );
endinterface

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer, IR decode and branch evaluation.
// Optional STUMP_CTRL_INSTR_COUNT_EN adds a 16-bit wrapping instruction counter.
module stump_control #(
    parameter logic [2:0] PC_REG = 3'd7
) (
    input  logic              clk,
    input  logic              rst,
    stump_control_if.master   bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   taken;
    logic   base_cond;
    logic   n_flag, z_flag, v_flag, c_flag;
    logic   is_ldst;

    assign is_ldst   = (bus.ir[15:13] == 3'b110);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = S_EXECUTE;
            S_EXECUTE: state_next = is_ldst ? S_MEMORY : S_FETCH;
            S_MEMORY:  state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // Odd condition codes are the complement of the even code just below them.
    always_comb begin
        n_flag    = bus.cc[3];
        z_flag    = bus.cc[2];
        v_flag    = bus.cc[1];
        c_flag    = bus.cc[0];
        base_cond = 1'b1;
        case (bus.ir[11:9])
            3'd0: base_cond = 1'b1;
            3'd1: base_cond = ~c_flag & ~z_flag;
            3'd2: base_cond = ~c_flag;
            3'd3: base_cond = ~z_flag;
            3'd4: base_cond = ~v_flag;
            3'd5: base_cond = ~n_flag;
            3'd6: base_cond = (n_flag == v_flag);
            3'd7: base_cond = ~z_flag & (n_flag == v_flag);
            default: base_cond = 1'b1;
        endcase
        taken = base_cond ^ bus.ir[8];
    end

    always_comb begin
        bus.fetch       = (state == S_FETCH);
        bus.execute     = (state == S_EXECUTE);
        bus.memory      = (state == S_MEMORY);
        bus.ext_op      = 1'b0;
        bus.opB_mux_sel = 1'b0;
        bus.shift_op    = 2'b00;
        bus.alu_func    = 3'b000;
        bus.cc_en       = 1'b0;
        bus.reg_write   = 1'b0;
        bus.dest        = PC_REG;
        bus.srcA        = PC_REG;
        bus.srcB        = 3'b000;
        case (state)
            S_FETCH: begin
                bus.reg_write = 1'b1;
            end
            S_EXECUTE: begin
                if (bus.ir[15:13] == 3'b111) begin
                    bus.alu_func    = 3'b111;
                    bus.opB_mux_sel = 1'b1;
                    bus.ext_op      = 1'b1;
                    bus.reg_write   = taken;
                end else begin
                    bus.alu_func = bus.ir[15:13];
                    bus.srcA     = bus.ir[7:5];
                    if (bus.ir[12]) begin
                        bus.opB_mux_sel = 1'b1;
                    end else begin
                        bus.srcB     = bus.ir[4:2];
                        bus.shift_op = bus.ir[1:0];
                    end
                    if (!is_ldst) begin
                        bus.dest      = bus.ir[10:8];
                        bus.reg_write = 1'b1;
                        bus.cc_en     = bus.ir[11];
                    end
                end
            end
            S_MEMORY: begin
                // ST reads the data register on port A; LD writes it back.
                if (bus.ir[11]) begin
                    bus.srcA = bus.ir[10:8];
                end else begin
                    bus.reg_write = 1'b1;
                    bus.dest      = bus.ir[10:8];
                end
            end
            default: ;
        endcase
        if (!rst) begin
            bus.reg_write = 1'b0;
            bus.cc_en     = 1'b0;
        end
    end

`ifdef STUMP_CTRL_INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  bus.instr_count <= 16'd0;
        else if (state == S_FETCH) bus.instr_count <= bus.instr_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stump_control.sv
// Bench for stump_control: directed steps, full branch-condition sweep and random
// instructions, all checked against a behavioural decode model.
module tb_stump_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;
    int         total = 0;
    int         bad = 0;
    int         exp_count = 0;

    stump_control_if bus();

    stump_control dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic branch_taken(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cond)
            4'h0: return 1'b1;
            4'h1: return 1'b0;
            4'h2: return !c && !z;
            4'h3: return c || z;
            4'h4: return !c;
            4'h5: return c;
            4'h6: return !z;
            4'h7: return z;
            4'h8: return !v;
            4'h9: return v;
            4'hA: return !n;
            4'hB: return n;
            4'hC: return n == v;
            4'hD: return n != v;
            4'hE: return !z && (n == v);
            default: return z || (n != v);
        endcase
    endfunction

    // Expected {ext_op, opB_mux_sel, shift_op, alu_func, cc_en, reg_write, dest, srcA, srcB}.
    // phase: 0 = fetch, 1 = execute, 2 = memory.
    function automatic logic [17:0] model(input int phase, input logic [15:0] i,
                                          input logic [3:0] f, input bit in_reset);
        logic       ext, opb, ccen, wr;
        logic [1:0] sh;
        logic [2:0] alu, d, a, b;
        int         op;
        op = int'(i[15:13]);
        ext = 0; opb = 0; sh = 0; alu = 0; ccen = 0; wr = 0; d = 7; a = 7; b = 0;
        if (phase == 0) begin
            wr = 1;
        end else if (phase == 1) begin
            if (op == 7) begin
                alu = 7; opb = 1; ext = 1;
                wr = branch_taken(i[11:8], f);
            end else begin
                alu = i[15:13];
                a = i[7:5];
                if (i[12]) opb = 1;
                else begin b = i[4:2]; sh = i[1:0]; end
                if (op < 6) begin d = i[10:8]; wr = 1; ccen = i[11]; end
            end
        end else begin
            if (i[11]) a = i[10:8];
            else begin wr = 1; d = i[10:8]; end
        end
        if (in_reset) begin wr = 0; ccen = 0; end
        return {ext, opb, sh, alu, ccen, wr, d, a, b};
    endfunction

    task automatic check_phase(input string tag, input int phase, input bit in_reset);
        logic [2:0]  exp_oh;
        logic [17:0] obs_ctrl;
        exp_oh = (phase == 0) ? 3'b100 : (phase == 1) ? 3'b010 : 3'b001;
        obs_ctrl = {bus.ext_op, bus.opB_mux_sel, bus.shift_op, bus.alu_func, bus.cc_en,
                    bus.reg_write, bus.dest, bus.srcA, bus.srcB};
        check({tag, "_state"}, 32'({bus.fetch, bus.execute, bus.memory}), 32'(exp_oh));
        check({tag, "_ctrl"}, 32'(obs_ctrl), 32'(model(phase, bus.ir, bus.cc, in_reset)));
    endtask

    // Entered anywhere inside a FETCH cycle; leaves #1 after the edge that returns to FETCH.
    task automatic run_instr(input string tag, input logic [15:0] i, input logic [3:0] f,
                             input bit wiggle_cc);
        bus.ir = i;
        bus.cc = f;
        #1;
        check_phase({tag, "_f"}, 0, 0);
        @(posedge clk);
        exp_count++;
        #1;
        check_phase({tag, "_e"}, 1, 0);
        if (wiggle_cc) begin
            bus.cc = 4'($urandom_range(0, 15));
            #1;
            check_phase({tag, "_e_cc"}, 1, 0);
        end
        if (i[15:13] == 3'b110) begin
            @(posedge clk);
            #1;
            check_phase({tag, "_m"}, 2, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ir = 16'($urandom);
        bus.cc = 4'($urandom);

        // Reset held over several edges, with IR changing underneath.
        repeat (3) begin
            @(posedge clk);
            bus.ir = 16'($urandom);
        end
        #1;
        check_phase("reset_hold", 0, 1);
        exp_count = 0;
`ifdef STUMP_CTRL_INSTR_COUNT_EN
        check("count_reset", 32'(bus.instr_count), 32'(exp_count));
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_phase("reset_release", 0, 0);
        check("reset_release_dest", 32'(bus.dest), 32'd7);

        run_instr("add", 16'h0864, 4'h0, 0);
        run_instr("ld",  16'hD4A3, 4'h0, 0);
        run_instr("st",  16'hDCA3, 4'h0, 0);
        run_instr("beq_taken", 16'hF7FE, 4'b0100, 0);
        check("beq_taken_back_in_fetch", 32'(bus.fetch), 32'd1);
        bus.cc = 4'b0100;
        #1;
        @(posedge clk);
        #1;
        check("beq_z1_write", 32'(bus.reg_write), 32'd1);
        check("beq_z1_ext", 32'(bus.ext_op), 32'd1);
        check("beq_z1_dest", 32'(bus.dest), 32'd7);
        exp_count++;
        @(posedge clk);
        #1;
        bus.cc = 4'b0000;
        @(posedge clk);
        #1;
        check("beq_z0_write", 32'(bus.reg_write), 32'd0);
        exp_count++;
        @(posedge clk);
        #1;

        for (int cond = 0; cond < 16; cond++) begin
            for (int f = 0; f < 16; f++) begin
                run_instr("sweep", {3'b111, 1'($urandom), 4'(cond), 8'($urandom)}, 4'(f), 0);
            end
        end

        for (int k = 0; k < 300; k++) begin
            run_instr("rand", 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset arriving mid-MEMORY abandons the load immediately.
        bus.ir = 16'hD4A3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_phase("pre_reset_mem", 2, 0);
        #2;
        rst = 1'b0;
        #1;
        check_phase("async_reset_mem", 0, 1);
        exp_count = 0;
`ifdef STUMP_CTRL_INSTR_COUNT_EN
        check("count_after_async", 32'(bus.instr_count), 32'(exp_count));
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_phase("resume_fetch", 0, 0);
        run_instr("resume_alu", 16'($urandom_range(0, 16'hBFFF)), 4'($urandom), 0);
`ifdef STUMP_CTRL_INSTR_COUNT_EN
        check("count_final", 32'(bus.instr_count), 32'(exp_count));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
